// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : div_pkg
//  Purpose : Shared definitions for the sequential restoring divider:
//            default operand width and the FSM state encoding.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package div_pkg;

  localparam int DEF_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_DONE = ST_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
//  Module  : seq_divider_if
//  Purpose : Operand and result handshakes of the sequential divider.
//  Ports   : master - drives in_valid/dividend/divisor/out_ready,
//                     observes in_ready and the result signals
//            slave  - the divider side (direction-mirrored)
//  Rev     : 1.0  initial release
// ============================================================================
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface
`default_nettype wire

// File: rtl/sub_unit.sv
`default_nettype none
// ============================================================================
//  Module  : sub_unit
//  Purpose : Combinational N-bit ripple subtractor, diff = a - b computed
//            as a + ~b + 1 through a chain of full-subtract cells.
//  Ports   : a, b    in   N  minuend / subtrahend
//            diff    out  N  a - b (modulo 2^N)
//            borrow  out  1  1 when a < b (inverted final carry)
//  Rev     : 1.0  initial release
// ============================================================================
module sub_unit
  import div_pkg::*;
#(
  parameter int N = DEF_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  // Carry chain; the +1 of the two's complement enters as carry-in.
  logic [N:0] w_c;

  assign w_c[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_cell
    logic w_nb;
    assign w_nb       = ~b[i];
    assign diff[i]    = a[i] ^ w_nb ^ w_c[i];
    assign w_c[i + 1] = (a[i] & w_nb) | (w_c[i] & (a[i] ^ w_nb));
  end

  // No carry out of a + ~b + 1 means the subtraction underflowed.
  assign borrow = ~w_c[N];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module  : seq_divider
//  Purpose : Multi-cycle unsigned restoring divider. One quotient bit per
//            cycle, MSB first; WIDTH iterations per operation, divide by
//            zero short-circuits straight to the result.
//  Ports   : clk  in  1  rising-edge clock
//            rst  in  1  synchronous active-high reset
//            bus  slave modport of seq_divider_if:
//                 in_valid/in_ready/dividend/divisor  operand handshake
//                 out_valid/out_ready/quotient/remainder/div_by_zero result
//  Rev     : 1.0  initial release
// ============================================================================
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_d;       // latched divisor
  logic [WIDTH-1:0] r_q;       // dividend shifting out / quotient shifting in
  logic [WIDTH:0]   r_r;       // partial remainder
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_dz;

  logic [WIDTH:0]   w_rs;
  logic [WIDTH:0]   w_t;
  logic             w_borrow;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH:0]   w_r_nxt;
  logic             w_accept;
  logic             w_div_zero;
  logic             w_last;
  logic             w_out_hs;

  // A stored remainder is always below D < 2^WIDTH, so the top bit of R
  // never carries information into the next shift.
  logic             w_unused_rtop;
  assign w_unused_rtop = r_r[WIDTH];

  // ---------------------------------------------------------------------
  // Datapath: shift the next dividend bit into R and trial-subtract D.
  // ---------------------------------------------------------------------
  assign w_rs = {r_r[WIDTH-1:0], r_q[WIDTH-1]};

  sub_unit #(
    .N (WIDTH + 1)
  ) u_sub (
    .a      (w_rs),
    .b      ({1'b0, r_d}),
    .diff   (w_t),
    .borrow (w_borrow)
  );

  // Restore (keep Rs) on borrow, otherwise commit the difference.
  assign w_q_nxt = {r_q[WIDTH-2:0], ~w_borrow};
  assign w_r_nxt = w_borrow ? w_rs : w_t;

  assign w_accept   = bus.in_valid & (r_state == S_IDLE);
  assign w_div_zero = (bus.divisor == '0);
  assign w_last     = (r_count == C_LAST);
  assign w_out_hs   = bus.out_ready & (r_state == S_DONE);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_div_zero ? S_DONE : S_CALC;
      S_CALC:  if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  if (w_out_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Working registers and result registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_count <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_d     <= bus.divisor;
            r_q     <= bus.dividend;
            r_r     <= '0;
            r_count <= '0;
            if (w_div_zero) begin
              r_quot <= '1;
              r_rem  <= bus.dividend;
              r_dz   <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_q <= w_q_nxt;
          r_r <= w_r_nxt;
          // Count stops at its final value so it never wraps mid-operation.
          if (!w_last) begin
            r_count <= r_count + CW'(1);
          end else begin
            r_quot <= w_q_nxt;
            r_rem  <= w_r_nxt[WIDTH-1:0];
            r_dz   <= 1'b0;
          end
        end
        default: begin
          // DONE: result registers hold while the consumer stalls.
        end
      endcase
    end
  end

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module  : tb_seq_divider
//  Purpose : Self-checking bench for seq_divider (WIDTH=4). Results are
//            compared against integer division in a reference function.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division; divisor 0 gives all-ones / dividend.
  function automatic void model(input int a, input int b, output int q, output int r, output int dz);
    if (b == 0) begin
      q = (1 << W) - 1; r = a; dz = 1;
    end else begin
      q = a / b; r = a % b; dz = 0;
    end
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) check({tag, "_idle_timeout"}, 32'(bus.in_ready), 1);
  endtask

  // One full operation: accept, measure latency, check result, optional
  // backpressure for 'hold' cycles, optional input noise while busy.
  task automatic do_op(input int a, input int b, input int hold, input bit noise, input string tag);
    int q, r, dz, lat, exp_lat;
    logic [W-1:0] va, vb;
    model(a, b, q, r, dz);
    exp_lat = (b == 0) ? 1 : W + 1;
    va = W'(a);
    vb = W'(b);
    wait_idle(tag);
    bus.in_valid = 1'b1;
    bus.dividend = va;
    bus.divisor  = vb;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      if (noise) begin
        bus.in_valid = 1'($urandom);
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
      end
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    if (bus.out_valid !== 1'b1) return;
    check({tag, "_quot"}, 32'(bus.quotient), q);
    check({tag, "_rem"},  32'(bus.remainder), r);
    check({tag, "_dz"},   32'(bus.div_by_zero), dz);
    if (b != 0) begin
      check({tag, "_inv"}, 32'(bus.quotient) * b + 32'(bus.remainder), a);
      check({tag, "_rlt"}, 32'(32'(bus.remainder) < b), 1);
    end
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        bus.in_valid = 1'($urandom);
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
      end
      tick();
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 1);
      check({tag, "_hold_inrdy"}, 32'(bus.in_ready), 0);
      check({tag, "_hold_quot"},  32'(bus.quotient), q);
      check({tag, "_hold_rem"},   32'(bus.remainder), r);
      check({tag, "_hold_dz"},    32'(bus.div_by_zero), dz);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_post_inrdy"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset_inrdy", 32'(bus.in_ready), 1);
    check("reset_valid", 32'(bus.out_valid), 0);
    check("reset_quot",  32'(bus.quotient), 0);
    check("reset_rem",   32'(bus.remainder), 0);
    check("reset_dz",    32'(bus.div_by_zero), 0);
    rst = 1'b0;
    tick();

    // Directed cases
    do_op(13, 4, 0, 1'b0, "d13_4");
    do_op(15, 1, 0, 1'b0, "d15_1");
    do_op(3,  9, 0, 1'b0, "d3_9");
    do_op(0,  5, 0, 1'b0, "d0_5");
    do_op(7,  0, 0, 1'b0, "d7_0");
    do_op(13, 4, 5, 1'b0, "bp13_4");
    do_op(7,  0, 3, 1'b0, "bp7_0");

    // Reset during the second CALC cycle aborts the operation
    wait_idle("rst_abort");
    bus.in_valid = 1'b1;
    bus.dividend = W'(13);
    bus.divisor  = W'(4);
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_inrdy", 32'(bus.in_ready), 1);
    check("abort_valid", 32'(bus.out_valid), 0);
    check("abort_quot",  32'(bus.quotient), 0);
    check("abort_rem",   32'(bus.remainder), 0);
    do_op(9, 2, 0, 1'b0, "d9_2");

    // Inputs changing while busy must not disturb the latched operands
    do_op(13, 4, 2, 1'b1, "noise13_4");
    do_op(11, 0, 2, 1'b1, "noise11_0");

    // Every operand pair
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        do_op(a, b, 0, 1'b0, "exh");
      end
    end

    // Random operands, random backpressure and noise
    for (int k = 0; k < 40; k++) begin
      do_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
            int'($urandom_range(0, 3)), 1'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
